// File: rtl/hazard_pkg.sv
// Shared types and helpers for the decode-stage hazard scoreboard.
package hazard_pkg;

  // Widest register address the shadow entries can hold; narrower AW is zero-extended.
  localparam int HZ_DEST_W  = 8;
  localparam int FWD_SEL_RF = 0;

  typedef logic [HZ_DEST_W-1:0] hz_dest_t;

  typedef struct packed {
    logic     valid;
    logic     wb_en;
    logic     mem_r_en;
    hz_dest_t dest;
  } hz_entry_t;

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Priority search of the in-flight writeback entries for one source operand.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = sel_w(DEPTH)
) (
  input  hz_entry_t         entries_i [DEPTH],
  input  hz_dest_t          addr_i,
  input  logic              req_i,
  input  logic              fwd_en_i,
  output logic              raw_o,
  output logic [SEL_W-1:0]  sel_o
);

  logic             found;
  logic             young_load;
  logic [SEL_W-1:0] young_sel;

  // Walk oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    found      = 1'b0;
    young_load = 1'b0;
    young_sel  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (entries_i[i].valid && entries_i[i].wb_en && (entries_i[i].dest == addr_i)) begin
        found      = 1'b1;
        young_load = entries_i[i].mem_r_en && (i < LOAD_LAT);
        young_sel  = SEL_W'(i + 1);
      end
    end
    raw_o = req_i && (fwd_en_i ? young_load : found);
    sel_o = (fwd_en_i && req_i && found && !raw_o) ? young_sel : SEL_W'(FWD_SEL_RF);
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: shadows in-flight writebacks, raises stall and forwarding selects.
// Optional stall_cnt output is built when HAZARD_STALL_CNT_EN is defined.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int AW       = 4,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = sel_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_src1,
  input  logic             id_src1_used,
  input  logic [AW-1:0]    id_src2,
  input  logic             id_two_src,
  input  logic [AW-1:0]    id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             fwd_en,
  input  logic             flush,
  output logic             hazard,
  output logic [SEL_W-1:0] fwd_sel1,
  output logic [SEL_W-1:0] fwd_sel2
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  hz_entry_t entries_q [DEPTH];
  hz_entry_t entries_d [DEPTH];
  logic      raw1;
  logic      raw2;
  logic      issue;

  hazard_match #(
    .DEPTH    (DEPTH),
    .LOAD_LAT (LOAD_LAT),
    .SEL_W    (SEL_W)
  ) u_match_src1 (
    .entries_i (entries_q),
    .addr_i    (hz_dest_t'(id_src1)),
    .req_i     (id_src1_used),
    .fwd_en_i  (fwd_en),
    .raw_o     (raw1),
    .sel_o     (fwd_sel1)
  );

  hazard_match #(
    .DEPTH    (DEPTH),
    .LOAD_LAT (LOAD_LAT),
    .SEL_W    (SEL_W)
  ) u_match_src2 (
    .entries_i (entries_q),
    .addr_i    (hz_dest_t'(id_src2)),
    .req_i     (id_two_src),
    .fwd_en_i  (fwd_en),
    .raw_o     (raw2),
    .sel_o     (fwd_sel2)
  );

  assign hazard = id_valid && !flush && (raw1 || raw2);
  assign issue  = id_valid && !hazard && !flush;

  // The shadow pipe always advances; a stall or flush only injects a bubble at EXE.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) entries_d[i] = '0;
    for (int i = 1; i < DEPTH; i++) entries_d[i] = entries_q[i-1];
    if (issue) begin
      entries_d[0].valid    = 1'b1;
      entries_d[0].wb_en    = id_wb_en;
      entries_d[0].mem_r_en = id_mem_r_en;
      entries_d[0].dest     = hz_dest_t'(id_dest);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  assign stall_cnt_d = (hazard && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1 : stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (AW=4, DEPTH=2, LOAD_LAT=1).
module tb_hazard_scoreboard;

  localparam int AW    = 4;
  localparam int DEPTH = 2;
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             id_valid;
  logic [AW-1:0]    id_src1;
  logic             id_src1_used;
  logic [AW-1:0]    id_src2;
  logic             id_two_src;
  logic [AW-1:0]    id_dest;
  logic             id_wb_en;
  logic             id_mem_r_en;
  logic             fwd_en;
  logic             flush;
  logic             hazard;
  logic [SEL_W-1:0] fwd_sel1;
  logic [SEL_W-1:0] fwd_sel2;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0]      stall_cnt;
`endif

  int chk_cnt;
  int err_cnt;

  hazard_scoreboard #(.AW(AW), .DEPTH(DEPTH), .LOAD_LAT(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_src1      (id_src1),
    .id_src1_used (id_src1_used),
    .id_src2      (id_src2),
    .id_two_src   (id_two_src),
    .id_dest      (id_dest),
    .id_wb_en     (id_wb_en),
    .id_mem_r_en  (id_mem_r_en),
    .fwd_en       (fwd_en),
    .flush        (flush),
    .hazard       (hazard),
    .fwd_sel1     (fwd_sel1),
    .fwd_sel2     (fwd_sel2)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [AW-1:0] s1, input logic s1u,
                          input logic [AW-1:0] s2, input logic two, input logic [AW-1:0] d,
                          input logic wb, input logic mr);
    id_valid     = v;
    id_src1      = s1;
    id_src1_used = s1u;
    id_src2      = s2;
    id_two_src   = two;
    id_dest      = d;
    id_wb_en     = wb;
    id_mem_r_en  = mr;
  endtask

  task automatic idle();
    drive_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    idle();
    tick();
    tick();
  endtask

  initial begin
    chk_cnt = 0;
    err_cnt = 0;
    rst_n   = 1'b0;
    fwd_en  = 1'b0;
    flush   = 1'b0;
    idle();
    #12;
    check("rst_hazard", {31'd0, hazard}, 32'd0);
    check("rst_sel1", 32'(fwd_sel1), 32'd0);
    check("rst_sel2", 32'(fwd_sel2), 32'd0);
    rst_n = 1'b1;
    tick();

    // RAW without forwarding: 2-cycle stall
    drive_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0);
    #2 check("nf_first_hz", {31'd0, hazard}, 32'd0);
    tick();
    drive_id(1'b1, 4'd3, 1'b1, 4'd5, 1'b1, 4'd4, 1'b1, 1'b0);
    #2 check("nf_stall0_hz", {31'd0, hazard}, 32'd1);
    check("nf_stall0_sel1", 32'(fwd_sel1), 32'd0);
    id_valid = 1'b0;
    #1 check("nf_novalid_hz", {31'd0, hazard}, 32'd0);
    id_valid = 1'b1;
    tick();
    check("nf_stall1_hz", {31'd0, hazard}, 32'd1);
    check("nf_stall1_sel1", 32'(fwd_sel1), 32'd0);
    tick();
    check("nf_clear_hz", {31'd0, hazard}, 32'd0);
    check("nf_clear_sel1", 32'(fwd_sel1), 32'd0);
    tick();
    drain();

    // ALU forwarding from EXE, then MEM
    fwd_en = 1'b1;
    drive_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);
    tick();
    drive_id(1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 4'd6, 1'b1, 1'b0);
    #2 check("fw_exe_hz", {31'd0, hazard}, 32'd0);
    check("fw_exe_sel1", 32'(fwd_sel1), 32'd1);
    check("fw_exe_sel2", 32'(fwd_sel2), 32'd1);
    tick();
    drive_id(1'b1, 4'd3, 1'b1, 4'd6, 1'b0, 4'd10, 1'b1, 1'b0);
    #2 check("fw_mem_sel1", 32'(fwd_sel1), 32'd2);
    check("fw_unreq_sel2", 32'(fwd_sel2), 32'd0);
    check("fw_mem_hz", {31'd0, hazard}, 32'd0);
    tick();
    drain();

    // Load-use: one stall, then forward from MEM
    drive_id(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1);
    tick();
    drive_id(1'b1, 4'd2, 1'b1, 4'd0, 1'b1, 4'd1, 1'b1, 1'b0);
    #2 check("ld_stall_hz", {31'd0, hazard}, 32'd1);
    check("ld_stall_sel1", 32'(fwd_sel1), 32'd0);
    check("ld_stall_sel2", 32'(fwd_sel2), 32'd0);
    tick();
    check("ld_fwd_hz", {31'd0, hazard}, 32'd0);
    check("ld_fwd_sel1", 32'(fwd_sel1), 32'd2);
    tick();
    drain();

    // Two writers of R7 in flight: youngest wins
    drive_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0);
    tick();
    drive_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0);
    tick();
    drive_id(1'b1, 4'd7, 1'b1, 4'd7, 1'b1, 4'd11, 1'b1, 1'b0);
    #2 check("yw_sel1", 32'(fwd_sel1), 32'd1);
    check("yw_sel2", 32'(fwd_sel2), 32'd1);
    fwd_en = 1'b0;
    #1 check("yw_nofwd_hz", {31'd0, hazard}, 32'd1);
    check("yw_nofwd_sel1", 32'(fwd_sel1), 32'd0);
    fwd_en = 1'b1;
    tick();
    drain();

    // Flush of a dependent instruction: no stall, bubble enters EXE
    fwd_en = 1'b0;
    drive_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);
    tick();
    drive_id(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd8, 1'b1, 1'b0);
    flush = 1'b1;
    #2 check("fl_hz", {31'd0, hazard}, 32'd0);
    tick();
    flush  = 1'b0;
    fwd_en = 1'b1;
    drive_id(1'b1, 4'd3, 1'b1, 4'd8, 1'b1, 4'd12, 1'b1, 1'b0);
    #2 check("fl_sel1", 32'(fwd_sel1), 32'd2);
    check("fl_bubble_sel2", 32'(fwd_sel2), 32'd0);
    check("fl_after_hz", {31'd0, hazard}, 32'd0);
    tick();
    drain();

    // Reset during a load-use stall
    drive_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1);
    tick();
    drive_id(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0);
    #2 check("rs_pre_hz", {31'd0, hazard}, 32'd1);
    rst_n = 1'b0;
    #1 check("rs_hz", {31'd0, hazard}, 32'd0);
    check("rs_sel1", 32'(fwd_sel1), 32'd0);
    check("rs_sel2", 32'(fwd_sel2), 32'd0);
`ifdef HAZARD_STALL_CNT_EN
    check("rs_cnt", stall_cnt, 32'd0);
`endif
    idle();
    #1 rst_n = 1'b1;
    tick();

    // Three stall cycles after reset: 2 without forwarding, 1 load-use
    fwd_en = 1'b0;
    drive_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);
    tick();
    drive_id(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b1);
    #2 check("sc_a_hz", {31'd0, hazard}, 32'd1);
    tick();
    tick();
    check("sc_b_hz", {31'd0, hazard}, 32'd0);
    tick();
    fwd_en = 1'b1;
    drive_id(1'b1, 4'd4, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0);
    #2 check("sc_c_hz", {31'd0, hazard}, 32'd1);
    tick();
    check("sc_c_sel1", 32'(fwd_sel1), 32'd2);
    tick();
    idle();
    tick();
`ifdef HAZARD_STALL_CNT_EN
    check("sc_cnt", stall_cnt, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
